bpu_update_ctrl: RTL and testbench

Sequencer for branch-predictor training. Accepts resolved-branch records from the EX/MEM stage, buffers them in a small FIFO, and drives the write ports of the branch prediction unit's PHT, GHR and BTB in a fixed two-cycle sequence per record. It also initialises the PHT after reset. Writes are held off while the prediction pipeline is stalled.

---
 rtl/bpu_pkg.sv | 23 ++
 rtl/bpu_update_fifo.sv | 54 +++++
 rtl/bpu_update_ctrl.sv | 125 ++++++++++++
 tb/tb_bpu_update_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: shared branch-type encodings, update FSM states and PHT counter helpers
package bpu_pkg;

    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_JAL  = 2'b01;
    localparam logic [1:0] BR_JALR = 2'b10;
    localparam logic [1:0] BR_RET  = 2'b11;

    localparam logic [1:0] PHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PHT_UPD,
        ST_BTB_UPD
    } upd_state_e;

    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                     : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// bpu_update_fifo: synchronous FIFO with occupancy count; caller never pushes when full or pops when empty
module bpu_update_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    // pointer and occupancy state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;

endmodule

// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: buffers resolved branches and sequences PHT/GHR then BTB training writes, with PHT init after reset
module bpu_update_ctrl #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         PHT_IDX_W   = 11,
    parameter int         PHT_ENTRIES = 2 ** PHT_IDX_W,
    parameter logic [1:0] PHT_INIT    = bpu_pkg::PHT_INIT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BPU__Stall,
    input  logic                 Res_Valid,
    output logic                 Res_Ready,
    input  logic [31:0]          Res_PC,
    input  logic [31:0]          Res_Target,
    input  logic [1:0]           Res_Type,
    input  logic                 Res_Taken,
    input  logic [PHT_IDX_W-1:0] Res_PHT_Index,
    input  logic [1:0]           Res_PHT_Data,
    output logic [PHT_IDX_W-1:0] PHT_Write_Index,
    output logic [1:0]           PHT_Write_Data,
    output logic                 PHT_Write_En,
    output logic                 GHR_Write_Data,
    output logic                 GHR_Write_En,
    output logic [31:0]          BTB_Write_Addr,
    output logic [31:0]          BTB_Write_Data,
    output logic                 BTB_Write_En,
    output logic                 Init_Busy
);

    import bpu_pkg::*;

    localparam int REC_W = 32 + 30 + 2 + 1 + PHT_IDX_W + 2;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PHT_IDX_W-1:0] INIT_LAST = PHT_IDX_W'(PHT_ENTRIES - 1);

    upd_state_e           state_q, state_d;
    logic [PHT_IDX_W-1:0] init_cnt_q, init_cnt_d;

    logic [REC_W-1:0]     rec_in, rec_head;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty, push, pop;

    logic [31:0]          h_pc;
    logic [29:0]          h_tgt;
    logic [1:0]           h_type, h_data;
    logic                 h_taken;
    logic [PHT_IDX_W-1:0] h_idx;

    logic                 init_st, init_wr, pht_st, btb_st, pht_go, btb_go, is_cond;
    logic                 unused_tgt_lsb;

    // the low target bits are implied by alignment and never stored
    assign unused_tgt_lsb = ^Res_Target[1:0];
    assign rec_in = {Res_PC, Res_Target[31:2], Res_Type, Res_Taken, Res_PHT_Index, Res_PHT_Data};
    assign {h_pc, h_tgt, h_type, h_taken, h_idx, h_data} = rec_head;

    assign init_st   = state_q == ST_INIT;
    assign init_wr   = init_st && RST_N;
    assign pht_st    = state_q == ST_PHT_UPD;
    assign btb_st    = state_q == ST_BTB_UPD;
    assign pht_go    = pht_st && !BPU__Stall;
    assign btb_go    = btb_st && !BPU__Stall;
    assign is_cond   = h_type == BR_COND;

    assign Init_Busy = init_st;
    assign Res_Ready = !init_st && !fifo_full;
    assign push      = Res_Valid && Res_Ready;
    assign pop       = btb_go;

    bpu_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // next state: init sweep, then two stall-aware steps per queued record
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = (init_cnt_q == INIT_LAST) ? '0 : init_cnt_q + 1'b1;
                state_d    = (init_cnt_q == INIT_LAST) ? ST_IDLE : ST_INIT;
            end
            ST_IDLE:    state_d = (!fifo_empty && !BPU__Stall) ? ST_PHT_UPD : ST_IDLE;
            ST_PHT_UPD: state_d = BPU__Stall ? ST_PHT_UPD : ST_BTB_UPD;
            ST_BTB_UPD: state_d = BPU__Stall ? ST_BTB_UPD
                                : (fifo_count > CW'(1) || push) ? ST_PHT_UPD : ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // FSM and sweep counter registers; reset restarts the PHT sweep from entry 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // write-port decode from state, FIFO head and sweep counter; PHT and BTB never share a cycle
    always_comb begin
        PHT_Write_En    = init_wr || (pht_go && is_cond);
        PHT_Write_Index = init_st ? init_cnt_q : (pht_st ? h_idx : '0);
        PHT_Write_Data  = init_wr ? PHT_INIT : (pht_st ? sat2_update(h_data, h_taken) : 2'b00);
        GHR_Write_En    = pht_go && is_cond;
        GHR_Write_Data  = pht_st && h_taken;
        BTB_Write_En    = btb_go && (!is_cond || h_taken);
        BTB_Write_Addr  = btb_st ? h_pc : '0;
        BTB_Write_Data  = btb_st ? {h_tgt, h_type} : '0;
    end

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb_bpu_update_ctrl: directed checks of init sweep, record sequencing, saturation, backpressure, stall and reset
module tb_bpu_update_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        BPU__Stall;
    logic        Res_Valid;
    logic        Res_Ready;
    logic [31:0] Res_PC;
    logic [31:0] Res_Target;
    logic [1:0]  Res_Type;
    logic        Res_Taken;
    logic [10:0] Res_PHT_Index;
    logic [1:0]  Res_PHT_Data;
    logic [10:0] PHT_Write_Index;
    logic [1:0]  PHT_Write_Data;
    logic        PHT_Write_En;
    logic        GHR_Write_Data;
    logic        GHR_Write_En;
    logic [31:0] BTB_Write_Addr;
    logic [31:0] BTB_Write_Data;
    logic        BTB_Write_En;
    logic        Init_Busy;

    int total = 0;
    int bad   = 0;

    bpu_update_ctrl dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .BPU__Stall      (BPU__Stall),
        .Res_Valid       (Res_Valid),
        .Res_Ready       (Res_Ready),
        .Res_PC          (Res_PC),
        .Res_Target      (Res_Target),
        .Res_Type        (Res_Type),
        .Res_Taken       (Res_Taken),
        .Res_PHT_Index   (Res_PHT_Index),
        .Res_PHT_Data    (Res_PHT_Data),
        .PHT_Write_Index (PHT_Write_Index),
        .PHT_Write_Data  (PHT_Write_Data),
        .PHT_Write_En    (PHT_Write_En),
        .GHR_Write_Data  (GHR_Write_Data),
        .GHR_Write_En    (GHR_Write_En),
        .BTB_Write_Addr  (BTB_Write_Addr),
        .BTB_Write_Data  (BTB_Write_Data),
        .BTB_Write_En    (BTB_Write_En),
        .Init_Busy       (Init_Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] tg, input logic [1:0] ty,
                           input logic tk, input logic [10:0] ix, input logic [1:0] dt);
        Res_PC        = pc;
        Res_Target    = tg;
        Res_Type      = ty;
        Res_Taken     = tk;
        Res_PHT_Index = ix;
        Res_PHT_Data  = dt;
    endtask

    task automatic push_rec(input logic [31:0] pc, input logic [31:0] tg, input logic [1:0] ty,
                            input logic tk, input logic [10:0] ix, input logic [1:0] dt);
        set_rec(pc, tg, ty, tk, ix, dt);
        Res_Valid = 1'b1;
        #1;
        chk("push_ready", Res_Ready, 1'b1);
        go();
        Res_Valid = 1'b0;
        #1;
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 2048; i++) begin
            chk(tag, {PHT_Write_En, PHT_Write_Data, PHT_Write_Index, Init_Busy, Res_Ready},
                {1'b1, 2'b01, 11'(i), 1'b1, 1'b0});
            go();
        end
        chk({tag, "_done"}, {Init_Busy, Res_Ready, PHT_Write_En}, 3'b010);
    endtask

    initial begin
        RST_N      = 1'b0;
        BPU__Stall = 1'b0;
        Res_Valid  = 1'b0;
        set_rec(32'h0, 32'h0, 2'b00, 1'b0, 11'h0, 2'b00);
        #3;
        chk("rst_ctrl", {Res_Ready, Init_Busy, PHT_Write_En, GHR_Write_En, BTB_Write_En}, 5'b01000);
        chk("rst_pht", {PHT_Write_Index, PHT_Write_Data, GHR_Write_Data}, 14'h0);
        chk("rst_btb", {BTB_Write_Addr, BTB_Write_Data}, 64'h0);
        go();
        go();
        RST_N = 1'b1;
        #1;
        init_sweep("init1");

        // single conditional, taken, counter 10 -> 11
        push_rec(32'h100, 32'h180, 2'b00, 1'b1, 11'h02A, 2'b10);
        chk("c1_wait", {PHT_Write_En, GHR_Write_En, BTB_Write_En}, 3'b000);
        go();
        chk("c1_pht", {PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {1'b1, 11'h02A, 2'b11});
        chk("c1_ghr", {GHR_Write_En, GHR_Write_Data, BTB_Write_En}, 3'b110);
        go();
        chk("c1_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data}, {1'b1, 32'h100, 32'h180});
        chk("c1_btb_only", {PHT_Write_En, GHR_Write_En}, 2'b00);
        go();
        chk("c1_idle", {PHT_Write_En, GHR_Write_En, BTB_Write_En}, 3'b000);

        // taken at saturation 11 stays 11
        push_rec(32'h104, 32'h200, 2'b00, 1'b1, 11'h010, 2'b11);
        go();
        chk("sat_hi_pht", {PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {1'b1, 11'h010, 2'b11});
        go();
        chk("sat_hi_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data}, {1'b1, 32'h104, 32'h200});
        go();

        // not-taken at floor 00 stays 00, GHR gets 0, no BTB write
        push_rec(32'h108, 32'h300, 2'b00, 1'b0, 11'h7FF, 2'b00);
        go();
        chk("sat_lo_pht", {PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {1'b1, 11'h7FF, 2'b00});
        chk("sat_lo_ghr", {GHR_Write_En, GHR_Write_Data}, 2'b10);
        go();
        chk("sat_lo_btb", {BTB_Write_En, PHT_Write_En}, 2'b00);
        go();

        // return: no PHT/GHR write, BTB data carries the type in the low bits
        push_rec(32'h200, 32'h344, 2'b11, 1'b1, 11'h055, 2'b10);
        go();
        chk("ret_pht", {PHT_Write_En, GHR_Write_En, BTB_Write_En}, 3'b000);
        go();
        chk("ret_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data}, {1'b1, 32'h200, 32'h347});
        go();

        // fill to depth while stalled, then drain in order; fifth accepted after the first pop
        BPU__Stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rec(32'h400 + 32'(4 * k), 32'h1000 + 32'(16 * k), 2'b01, 1'b1, 11'h0, 2'b00);
            Res_Valid = 1'b1;
            #1;
            chk("fill_ready", Res_Ready, 1'b1);
            go();
        end
        set_rec(32'h410, 32'h1040, 2'b01, 1'b1, 11'h0, 2'b00);
        #1;
        chk("full_ready", Res_Ready, 1'b0);
        BPU__Stall = 1'b0;
        go();
        chk("q0_pht", {PHT_Write_En, GHR_Write_En, BTB_Write_En, Res_Ready}, 4'b0000);
        go();
        chk("q0_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data}, {1'b1, 32'h400, 32'h1001});
        chk("q0_pop_ready", Res_Ready, 1'b0);
        go();
        chk("q1_pht_ready", {Res_Ready, PHT_Write_En, BTB_Write_En}, 3'b100);
        go();
        Res_Valid = 1'b0;
        #1;
        chk("q1_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data}, {1'b1, 32'h404, 32'h1011});
        for (int k = 2; k < 5; k++) begin
            go();
            chk("qn_pht", {PHT_Write_En, GHR_Write_En, BTB_Write_En}, 3'b000);
            go();
            chk("qn_btb", {BTB_Write_En, BTB_Write_Addr, BTB_Write_Data},
                {1'b1, 32'h400 + 32'(4 * k), 32'h1001 + 32'(16 * k)});
        end
        go();
        chk("q_drained", {PHT_Write_En, GHR_Write_En, BTB_Write_En, Res_Ready}, 4'b0001);

        // stall held for three cycles inside PHT_UPD: 2'b10 not-taken -> 2'b01
        push_rec(32'h500, 32'h520, 2'b00, 1'b0, 11'h123, 2'b10);
        go();
        BPU__Stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_en", {PHT_Write_En, GHR_Write_En, BTB_Write_En}, 3'b000);
            chk("stall_idx", PHT_Write_Index, 11'h123);
            if (k < 2) go();
        end
        BPU__Stall = 1'b0;
        #1;
        chk("stall_rel_pht", {PHT_Write_En, PHT_Write_Index, PHT_Write_Data}, {1'b1, 11'h123, 2'b01});
        chk("stall_rel_ghr", {GHR_Write_En, GHR_Write_Data, BTB_Write_En}, 3'b100);
        go();
        chk("stall_btb", {BTB_Write_En, PHT_Write_En}, 2'b00);
        go();

        // reset with three queued records: queue discarded, sweep restarts at 0 despite stall
        BPU__Stall = 1'b1;
        push_rec(32'h600, 32'h700, 2'b00, 1'b1, 11'h001, 2'b01);
        push_rec(32'h604, 32'h704, 2'b00, 1'b1, 11'h002, 2'b01);
        push_rec(32'h608, 32'h708, 2'b00, 1'b1, 11'h003, 2'b01);
        RST_N = 1'b0;
        #1;
        chk("rst2_low", {Init_Busy, Res_Ready, PHT_Write_En, BTB_Write_En}, 4'b1000);
        go();
        RST_N = 1'b1;
        #1;
        init_sweep("init2");
        BPU__Stall = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst2_empty", {PHT_Write_En, GHR_Write_En, BTB_Write_En, Res_Ready}, 4'b0001);
            go();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
